// File: rtl/ra_writer_pkg.sv
// Shared PVR region-array definitions.
// Common to the RA builder and the RA parser.
package ra_writer_pkg;

    localparam int RA_LAST      = 31;
    localparam int RA_ZCLEAR    = 30;
    localparam int RA_FLUSH     = 28;
    localparam int RA_TILEY_LSB = 8;
    localparam int RA_TILEX_LSB = 2;
    localparam int RA_TILE_W    = 6;

    localparam logic [31:0] RA_PTR_UNUSED = 32'h8000_0000;
    localparam logic [31:0] OL_EOL_WORD   = 32'hF000_0000;

    localparam int FPU_RA_V2 = 21;

    localparam int NTYPES = 5;
    typedef enum logic [2:0] {OL_O, OL_OM, OL_T, OL_TM, OL_PT} ol_type_e;
    localparam int TA_LSB [NTYPES] = '{0, 4, 8, 12, 16};

    typedef logic [NTYPES-1:0][1:0]  codes_t;
    typedef logic [NTYPES-1:0][23:0] ptrs_t;

    function automatic logic [1:0] ta_code(input logic [31:0] ctrl,
                                           input int t);
        return ctrl[TA_LSB[t] +: 2];
    endfunction

endpackage

// File: rtl/ra_ol_ptr_gen.sv
// Object-list segment bases and per-type running pointers.
// Segments are packed back to back in type order.
module ra_ol_ptr_gen
    import ra_writer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [23:0]       ol_base,
    input  codes_t            codes,
    input  logic [11:0]       ntiles,
    input  logic              load,
    input  logic              adv,
    output logic [NTYPES-1:0] used,
    output ptrs_t             ptr
);

    ptrs_t seg;
    ptrs_t step;
    ptrs_t span;

    always_comb begin
        for (int t = 0; t < NTYPES; t++) begin
            used[t] = codes[t] != 2'd0;
            step[t] = used[t] ? (24'd16 << codes[t]) : 24'd0;
            span[t] = used[t]
                    ? ({12'd0, ntiles} << (3'd4 + {1'b0, codes[t]}))
                    : 24'd0;
        end
        seg[0] = ol_base;
        for (int t = 1; t < NTYPES; t++) begin
            seg[t] = seg[t-1] + span[t-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= seg;
        end else if (adv) begin
            for (int t = 0; t < NTYPES; t++) begin
                ptr[t] <= ptr[t] + step[t];
            end
        end
    end

endmodule

// File: rtl/ra_writer.sv
// Region Array builder: walks the tile grid and writes RA
// entries, optionally seeding each OPB with an EOL word.
module ra_writer
    import ra_writer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ra_build_trig,
    input  logic [31:0] REGION_BASE,
    input  logic [31:0] OL_BASE,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] TA_ALLOC_CTRL,
    input  logic [5:0]  tiles_x_m1,
    input  logic [5:0]  tiles_y_m1,
    input  logic        zclear,
    input  logic        flush,
    input  logic        init_ol,
    input  logic        vram_wait,
    output logic        vram_wr,
    output logic [23:0] vram_addr,
    output logic [31:0] vram_dout,
    output logic        busy,
    output logic        done,
    output logic [23:0] ra_end_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_BASE, S_RA_WR, S_OL_WR, S_ADV, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [23:0] region_q, olbase_q, ra_addr_q;
    codes_t      codes_q;
    logic        v2_q, zclear_q, flush_q, init_q;
    logic [5:0]  tx_m1_q, ty_m1_q, x_q, y_q;
    logic [2:0]  widx_q, cur;
    logic [NTYPES-1:0] pend_q, pend_nxt, used;
    ptrs_t       ptr;
    logic [6:0]  nx, ny;
    logic [13:0] prod;
    logic [11:0] ntiles;
    logic        last_tile, last_word, accept;
    logic [31:0] ctrl_word;
    logic        unused_ok;

    assign unused_ok = ^{REGION_BASE[31:24], OL_BASE[31:24],
                         FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                         TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                         TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                         TA_ALLOC_CTRL[3:2], prod[13:12]};

    assign nx        = {1'b0, tx_m1_q} + 7'd1;
    assign ny        = {1'b0, ty_m1_q} + 7'd1;
    assign prod      = nx * ny;
    assign ntiles    = prod[11:0];
    assign last_tile = (x_q == tx_m1_q) && (y_q == ty_m1_q);
    assign last_word = widx_q == (v2_q ? 3'd5 : 3'd4);
    assign accept    = vram_wr & ~vram_wait;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;

    ra_ol_ptr_gen u_ptr (
        .clock   (clock),
        .reset   (reset),
        .ol_base (olbase_q),
        .codes   (codes_q),
        .ntiles  (ntiles),
        .load    (state_q == S_BASE),
        .adv     (state_q == S_ADV),
        .used    (used),
        .ptr     (ptr)
    );

    // Lowest pending type is the next EOL target.
    always_comb begin
        cur = 3'd0;
        for (int t = NTYPES - 1; t >= 0; t--) begin
            if (pend_q[t]) cur = 3'(t);
        end
        pend_nxt = pend_q & ~(NTYPES'(1) << cur);
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[RA_LAST]   = last_tile;
        ctrl_word[RA_ZCLEAR] = zclear_q;
        ctrl_word[RA_FLUSH]  = flush_q;
        ctrl_word[RA_TILEY_LSB +: RA_TILE_W] = y_q;
        ctrl_word[RA_TILEX_LSB +: RA_TILE_W] = x_q;
    end

    always_comb begin
        vram_wr   = 1'b0;
        vram_addr = '0;
        vram_dout = '0;
        unique case (state_q)
            S_RA_WR: begin
                vram_wr   = 1'b1;
                vram_addr = ra_addr_q;
                if (widx_q == 3'd0)
                    vram_dout = ctrl_word;
                else if (used[widx_q - 3'd1])
                    vram_dout = {8'h00, ptr[widx_q - 3'd1]};
                else
                    vram_dout = RA_PTR_UNUSED;
            end
            S_OL_WR: begin
                vram_wr   = 1'b1;
                vram_addr = ptr[cur];
                vram_dout = OL_EOL_WORD;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ra_build_trig) state_d = S_LATCH;
            S_LATCH: state_d = S_BASE;
            S_BASE:  state_d = S_RA_WR;
            S_RA_WR: begin
                if (accept && last_word)
                    state_d = (init_q && |used) ? S_OL_WR : S_ADV;
            end
            S_OL_WR: if (accept && pend_nxt == '0) state_d = S_ADV;
            S_ADV:   state_d = last_tile ? S_DONE : S_RA_WR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            region_q    <= '0;
            olbase_q    <= '0;
            ra_addr_q   <= '0;
            codes_q     <= '0;
            v2_q        <= 1'b0;
            zclear_q    <= 1'b0;
            flush_q     <= 1'b0;
            init_q      <= 1'b0;
            tx_m1_q     <= '0;
            ty_m1_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            widx_q      <= '0;
            pend_q      <= '0;
            ra_end_addr <= '0;
        end else begin
            unique case (state_q)
                S_LATCH: begin
                    region_q <= REGION_BASE[23:0];
                    olbase_q <= OL_BASE[23:0];
                    v2_q     <= FPU_PARAM_CFG[FPU_RA_V2];
                    zclear_q <= zclear;
                    flush_q  <= flush;
                    init_q   <= init_ol;
                    tx_m1_q  <= tiles_x_m1;
                    ty_m1_q  <= tiles_y_m1;
                    for (int t = 0; t < NTYPES; t++)
                        codes_q[t] <= ta_code(TA_ALLOC_CTRL, t);
                end
                S_BASE: begin
                    ra_addr_q <= region_q;
                    x_q       <= '0;
                    y_q       <= '0;
                    widx_q    <= '0;
                end
                S_RA_WR: begin
                    if (accept) begin
                        ra_addr_q <= ra_addr_q + 24'd4;
                        if (last_word) begin
                            widx_q <= '0;
                            pend_q <= init_q ? used : '0;
                        end else begin
                            widx_q <= widx_q + 3'd1;
                        end
                    end
                end
                S_OL_WR: if (accept) pend_q <= pend_nxt;
                S_ADV: begin
                    if (last_tile) begin
                        ra_end_addr <= ra_addr_q;
                    end else if (x_q == tx_m1_q) begin
                        x_q <= '0;
                        y_q <= y_q + 6'd1;
                    end else begin
                        x_q <= x_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ra_writer.sv
// Scoreboard bench for ra_writer against a tile-indexed
// reference model of the RA/OL layout.
module tb_ra_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ra_build_trig = 1'b0;
    logic [31:0] REGION_BASE = '0;
    logic [31:0] OL_BASE = '0;
    logic [31:0] FPU_PARAM_CFG = '0;
    logic [31:0] TA_ALLOC_CTRL = '0;
    logic [5:0]  tiles_x_m1 = '0;
    logic [5:0]  tiles_y_m1 = '0;
    logic        zclear = 1'b0;
    logic        flush = 1'b0;
    logic        init_ol = 1'b0;
    logic        vram_wait = 1'b0;
    logic        vram_wr;
    logic [23:0] vram_addr;
    logic [31:0] vram_dout;
    logic        busy;
    logic        done;
    logic [23:0] ra_end_addr;

    always #5 clock = ~clock;

    ra_writer dut (
        .clock         (clock),
        .reset         (reset),
        .ra_build_trig (ra_build_trig),
        .REGION_BASE   (REGION_BASE),
        .OL_BASE       (OL_BASE),
        .FPU_PARAM_CFG (FPU_PARAM_CFG),
        .TA_ALLOC_CTRL (TA_ALLOC_CTRL),
        .tiles_x_m1    (tiles_x_m1),
        .tiles_y_m1    (tiles_y_m1),
        .zclear        (zclear),
        .flush         (flush),
        .init_ol       (init_ol),
        .vram_wait     (vram_wait),
        .vram_wr       (vram_wr),
        .vram_addr     (vram_addr),
        .vram_dout     (vram_dout),
        .busy          (busy),
        .done          (done),
        .ra_end_addr   (ra_end_addr)
    );

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] rb, ob, fpu, ta;
        logic [5:0]  tx, ty;
        logic        z, f, io;
    } cfg_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  trig_cyc = 0;
    int  stall_cnt = 0;
    int  exp_cycles = 0;
    logic [23:0] exp_end = '0;
    logic [23:0] st_addr = '0;
    logic [31:0] st_data = '0;
    bit  first_pend = 0;
    bit  in_stall = 0;
    bit  done_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference model: every word derived directly from tile index.
    task automatic expect_build(input cfg_t c);
        int nx, ny, n, nused, w;
        int bytes [5];
        logic [23:0] base [5];
        logic [23:0] acc, ra, p;
        logic [1:0] code;
        logic [31:0] ctrl;
        bit v2;
        nx = int'(c.tx) + 1;
        ny = int'(c.ty) + 1;
        n = nx * ny;
        v2 = c.fpu[21];
        acc = c.ob[23:0];
        nused = 0;
        for (int t = 0; t < 5; t++) begin
            code = c.ta[4*t +: 2];
            bytes[t] = (code == 2'd0) ? 0 : (16 << code);
            base[t] = acc;
            if (code != 2'd0) begin
                acc = acc + 24'(n * bytes[t]);
                nused++;
            end
        end
        ra = c.rb[23:0];
        for (int i = 0; i < n; i++) begin
            ctrl = ((i == n - 1) ? 32'h8000_0000 : 32'h0)
                 | (c.z ? 32'h4000_0000 : 32'h0)
                 | (c.f ? 32'h1000_0000 : 32'h0)
                 | (32'(i / nx) << 8) | (32'(i % nx) << 2);
            exp_q.push_back('{ra, ctrl});
            ra = ra + 24'd4;
            for (int t = 0; t < (v2 ? 5 : 4); t++) begin
                p = base[t] + 24'(i * bytes[t]);
                exp_q.push_back('{ra, (bytes[t] == 0)
                                  ? 32'h8000_0000 : {8'h00, p}});
                ra = ra + 24'd4;
            end
            if (c.io) begin
                for (int t = 0; t < 5; t++) begin
                    p = base[t] + 24'(i * bytes[t]);
                    if (bytes[t] != 0)
                        exp_q.push_back('{p, 32'hF000_0000});
                end
            end
        end
        exp_end = ra;
        w = (v2 ? 6 : 5) + (c.io ? nused : 0);
        exp_cycles = 3 + n * (w + 1) + 1;
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (!reset) begin
            if (vram_wr) begin
                if (first_pend) begin
                    check("first_wr_latency", 32'(cyc), 32'(trig_cyc + 3));
                    first_pend = 0;
                end
                if (in_stall) begin
                    check("stall_addr", {8'h0, vram_addr}, {8'h0, st_addr});
                    check("stall_data", vram_dout, st_data);
                end
                if (vram_wait) begin
                    in_stall = 1;
                    st_addr = vram_addr;
                    st_data = vram_dout;
                    stall_cnt++;
                end else begin
                    in_stall = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %h data %h, required none",
                                 vram_addr, vram_dout);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", {8'h0, vram_addr}, {8'h0, e.addr});
                        check("wr_data", vram_dout, e.data);
                    end
                end
            end else begin
                in_stall = 0;
            end
            if (done) begin
                check("leftover_writes", 32'(exp_q.size()), 32'd0);
                check("ra_end_addr", {8'h0, ra_end_addr}, {8'h0, exp_end});
                check("build_cycles", 32'(cyc - trig_cyc + 1),
                      32'(exp_cycles + stall_cnt));
                done_seen = 1;
            end
        end
    end

    task automatic drive_cfg(input cfg_t c);
        REGION_BASE   = c.rb;
        OL_BASE       = c.ob;
        FPU_PARAM_CFG = c.fpu;
        TA_ALLOC_CTRL = c.ta;
        tiles_x_m1    = c.tx;
        tiles_y_m1    = c.ty;
        zclear        = c.z;
        flush         = c.f;
        init_ol       = c.io;
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.rb  = $urandom & 32'hFFFF_FFFC;
        c.ob  = $urandom & 32'hFFFF_FFFC;
        c.fpu = $urandom;
        c.ta  = $urandom;
        c.tx  = 6'($urandom_range(0, 5));
        c.ty  = 6'($urandom_range(0, 5));
        c.z   = 1'($urandom);
        c.f   = 1'($urandom);
        c.io  = 1'($urandom);
        return c;
    endfunction

    task automatic start_build(input cfg_t c);
        @(posedge clock);
        #1;
        drive_cfg(c);
        exp_q.delete();
        expect_build(c);
        stall_cnt = 0;
        in_stall = 0;
        done_seen = 0;
        first_pend = 1;
        trig_cyc = cyc;
        ra_build_trig = 1'b1;
        @(posedge clock);
        #1;
        ra_build_trig = 1'b0;
        check("busy_after_trig", 32'(busy), 32'd1);
    endtask

    // mode 0: no stalls, 1: random stalls, 2: 5-cycle stall on word 3
    task automatic finish_build(input int mode, input bit extra_trig,
                                input bit done_trig);
        int k = 0;
        int done_cyc = trig_cyc + exp_cycles - 1;
        while (!done_seen && k < 20000) begin
            if (mode == 1)
                vram_wait = ($urandom_range(0, 3) == 0);
            else
                vram_wait = (mode == 2) && (cyc >= trig_cyc + 5)
                            && (cyc <= trig_cyc + 9);
            if (cyc == trig_cyc + 3) drive_cfg(rand_cfg());
            ra_build_trig = (extra_trig && cyc == trig_cyc + 6)
                          || (done_trig && cyc == done_cyc);
            @(posedge clock);
            #1;
            k++;
        end
        vram_wait = 1'b0;
        ra_build_trig = 1'b0;
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL build_timeout: got no done, required done within 20000 cycles");
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            exp_q.delete();
        end else begin
            check("idle_after_done", {30'd0, busy, vram_wr}, 32'd0);
            @(posedge clock);
            #1;
            check("still_idle", {30'd0, busy, vram_wr}, 32'd0);
        end
    endtask

    cfg_t c1, c2, c3;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_vram_wr", 32'(vram_wr), 32'd0);
        check("rst_vram_addr", {8'h0, vram_addr}, 32'd0);
        check("rst_vram_dout", vram_dout, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_end_addr", {8'h0, ra_end_addr}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        c1 = '{rb: 32'h1000, ob: 32'h2000, fpu: 32'h0, ta: 32'h1,
               tx: 6'd1, ty: 6'd0, z: 1'b0, f: 1'b0, io: 1'b0};
        start_build(c1);
        finish_build(0, 0, 0);
        check("spec_end_addr", {8'h0, ra_end_addr}, 32'h1028);

        c1.io = 1'b1;
        start_build(c1);
        finish_build(0, 0, 0);

        c2 = '{rb: 32'h8000, ob: 32'h4000, fpu: 32'h0020_0000,
               ta: 32'h0003_0201, tx: 6'd0, ty: 6'd1,
               z: 1'b1, f: 1'b1, io: 1'b0};
        start_build(c2);
        finish_build(0, 0, 0);

        c3 = '{rb: 32'h0100, ob: 32'h0900, fpu: 32'h0,
               ta: 32'h0001_1111, tx: 6'd2, ty: 6'd1,
               z: 1'b0, f: 1'b1, io: 1'b1};
        start_build(c3);
        finish_build(2, 0, 0);

        start_build(c3);
        finish_build(0, 1, 0);

        start_build(c2);
        finish_build(0, 0, 1);

        start_build(c3);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        first_pend = 0;
        in_stall = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_vram_wr", 32'(vram_wr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        start_build(c3);
        finish_build(0, 0, 0);

        c2.ta = 32'h0;
        c2.io = 1'b1;
        start_build(c2);
        finish_build(1, 0, 0);

        c1 = '{rb: 32'hFFFFF8, ob: 32'hFFFFE0, fpu: 32'h0020_0000,
               ta: 32'h0001_3302, tx: 6'd1, ty: 6'd1,
               z: 1'b1, f: 1'b0, io: 1'b1};
        start_build(c1);
        finish_build(1, 0, 0);

        for (int i = 0; i < 20; i++) begin
            start_build(rand_cfg());
            finish_build(i % 2, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
